// File: rtl/i2c_reg_seq_loader_if.sv
// i2c_reg_seq_loader_if: byte-level command bus between the loader and an I2C byte controller.
interface i2c_reg_seq_loader_if;
   logic       cmd_start;
   logic       cmd_stop;
   logic       cmd_read;
   logic       cmd_write;
   logic       cmd_ack_in;
   logic [7:0] cmd_din;
   logic       cmd_ack;
   logic       ack_out;
   logic [7:0] dout;
   modport master (output cmd_start, cmd_stop, cmd_read, cmd_write, cmd_ack_in, cmd_din,
                   input  cmd_ack, ack_out, dout);
   modport slave  (input  cmd_start, cmd_stop, cmd_read, cmd_write, cmd_ack_in, cmd_din,
                   output cmd_ack, ack_out, dout);
endinterface

// File: rtl/i2c_reg_seq_loader.sv
// i2c_reg_seq_loader: walks a register ROM and writes (optionally reads back) each entry over a byte-level I2C master.
module i2c_reg_seq_loader #(
   parameter logic [6:0] SLAVE_ADDR   = 7'h74,
   parameter int         ADDR_BYTES   = 2,
   parameter int         MEM_DEPTH    = 512,
   parameter int         PAUSE_CYCLES = 10,
   parameter int         DELAY_UNIT   = 1000,
   parameter int         MAX_RETRY    = 3
) (
   input  logic                         clk_i,
   input  logic                         arstn_i,
   input  logic                         start_i,
   input  logic                         verify_i,
   output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
   input  logic [ADDR_BYTES*8+7:0]      rom_data_i,
   i2c_reg_seq_loader_if.master         bus,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [$clog2(MEM_DEPTH)-1:0] err_idx_o
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam int DW = ADDR_BYTES*8+8;
   localparam int RW = $clog2(MAX_RETRY+1) > 0 ? $clog2(MAX_RETRY+1) : 1;
   localparam logic [2:0]    LAST_WR   = 3'(ADDR_BYTES+1);
   localparam logic [2:0]    LAST_RD   = 3'(ADDR_BYTES+2);
   localparam logic [AW-1:0] LAST_IDX  = AW'(MEM_DEPTH-1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [31:0]   PAUSE_LD  = 32'(PAUSE_CYCLES-1);
   localparam logic [31:0]   UNIT      = 32'(DELAY_UNIT);

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, DELAY, ISSUE, WAIT_ACK, ABORT_STOP, WAIT_STOP, GAP, NEXT, FINISH
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d, err_idx_q, err_idx_d;
   logic [DW-1:0]   entry_q, entry_d;
   logic [2:0]      step_q, step_d;
   logic            rd_q, rd_d, redo_q, redo_d, verify_q, verify_d, err_q, err_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [12:0]     cmd_q, cmd_d, issue_cmd;
   logic [7:0]      addr_byte;
   logic            wa_ack, rd_step, last_wr, nack, mism, fail_ack, abort, ok, fail, can_retry, is_delay, cnt_zero;

   assign {bus.cmd_start, bus.cmd_stop, bus.cmd_read, bus.cmd_write, bus.cmd_ack_in, bus.cmd_din} = cmd_q;
   assign rom_addr_o = idx_q;
   assign err_o      = err_q;
   assign err_idx_o  = err_idx_q;
   assign busy_o     = state_q != IDLE && state_q != FINISH;
   assign done_o     = state_q == FINISH;

   assign wa_ack    = state_q == WAIT_ACK && bus.cmd_ack;
   assign rd_step   = rd_q && step_q == LAST_RD;
   assign last_wr   = !rd_q && step_q == LAST_WR;
   assign nack      = bus.ack_out && !rd_step;
   assign mism      = rd_step && bus.dout != entry_q[7:0];
   assign fail_ack  = wa_ack && ((nack && last_wr) || mism);
   assign abort     = wa_ack && nack && !last_wr;
   assign ok        = wa_ack && !nack && !mism && (rd_step || (last_wr && !verify_q));
   assign fail      = fail_ack || (state_q == WAIT_STOP && bus.cmd_ack);
   assign can_retry = retry_q < RETRY_MAX;
   assign is_delay  = &rom_data_i[DW-1:8];
   assign cnt_zero  = cnt_q == '0;
   assign addr_byte = 8'(entry_q >> (8*(ADDR_BYTES+1-int'(step_q))));

   // {start, stop, read, write, ack_in, din}; steps 1..ADDR_BYTES carry the register address MSB first
   assign issue_cmd = step_q == 3'd0             ? {5'b10010, SLAVE_ADDR, 1'b0}
                    : rd_q && step_q == LAST_WR  ? {5'b10010, SLAVE_ADDR, 1'b1}
                    : rd_q && step_q == LAST_RD  ? {5'b01101, 8'h00}
                    : step_q == LAST_WR          ? {5'b01010, entry_q[7:0]}
                    :                              {5'b00010, addr_byte};

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         err_idx_q <= '0;
         entry_q   <= '0;
         step_q    <= '0;
         rd_q      <= 1'b0;
         redo_q    <= 1'b0;
         verify_q  <= 1'b0;
         err_q     <= 1'b0;
         retry_q   <= '0;
         cnt_q     <= '0;
         cmd_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         err_idx_q <= err_idx_d;
         entry_q   <= entry_d;
         step_q    <= step_d;
         rd_q      <= rd_d;
         redo_q    <= redo_d;
         verify_q  <= verify_d;
         err_q     <= err_d;
         retry_q   <= retry_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       state_d = start_i ? FETCH : IDLE;
         FETCH:      state_d = DECODE;
         DECODE:     state_d = !is_delay ? ISSUE : |rom_data_i[7:0] ? DELAY : GAP;
         DELAY:      state_d = cnt_zero ? GAP : DELAY;
         ISSUE:      state_d = WAIT_ACK;
         WAIT_ACK:   state_d = !bus.cmd_ack ? WAIT_ACK
                             : abort ? ABORT_STOP
                             : fail_ack ? (can_retry ? GAP : FINISH)
                             : ok ? GAP : ISSUE;
         ABORT_STOP: state_d = WAIT_STOP;
         WAIT_STOP:  state_d = !bus.cmd_ack ? WAIT_STOP : can_retry ? GAP : FINISH;
         GAP:        state_d = !cnt_zero ? GAP : redo_q ? ISSUE : NEXT;
         NEXT:       state_d = idx_q == LAST_IDX ? FINISH : FETCH;
         FINISH:     state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      idx_d     = idx_q;
      err_idx_d = err_idx_q;
      entry_d   = entry_q;
      step_d    = step_q;
      rd_d      = rd_q;
      redo_d    = redo_q;
      verify_d  = verify_q;
      err_d     = err_q;
      retry_d   = retry_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      if (state_q == IDLE && start_i) begin
         idx_d    = '0;
         retry_d  = '0;
         redo_d   = 1'b0;
         err_d    = 1'b0;
         verify_d = verify_i;
      end
      if (state_q == DECODE) begin
         entry_d = rom_data_i;
         step_d  = '0;
         rd_d    = 1'b0;
         cnt_d   = is_delay && |rom_data_i[7:0] ? 32'(rom_data_i[7:0]) * UNIT - 32'd1 : PAUSE_LD;
      end
      if (state_q == DELAY || state_q == GAP) cnt_d = cnt_zero ? PAUSE_LD : cnt_q - 32'd1;
      if (state_q == GAP && cnt_zero) redo_d = 1'b0;
      if (state_q == ISSUE) cmd_d = issue_cmd;
      if (state_q == ABORT_STOP) cmd_d = {5'b01000, 8'h00};
      if ((state_q == WAIT_ACK || state_q == WAIT_STOP) && bus.cmd_ack) cmd_d = '0;
      if (wa_ack && !fail_ack && !abort && !ok) begin
         rd_d   = rd_q || last_wr;
         step_d = last_wr ? 3'd0 : step_q + 3'd1;
      end
      if (ok) cnt_d = PAUSE_LD;
      // a failed entry restarts from its device-address byte in the write phase
      if (fail && can_retry) begin
         retry_d = retry_q + 1'b1;
         redo_d  = 1'b1;
         rd_d    = 1'b0;
         step_d  = '0;
         cnt_d   = PAUSE_LD;
      end
      if (fail && !can_retry) begin
         err_d     = 1'b1;
         err_idx_d = idx_q;
      end
      if (state_q == NEXT) begin
         retry_d = '0;
         idx_d   = idx_q == LAST_IDX ? idx_q : idx_q + 1'b1;
      end
      if (state_q == FINISH) idx_d = '0;
   end
endmodule

// File: tb/tb_i2c_reg_seq_loader.sv
// tb_i2c_reg_seq_loader: directed vectors against a byte-controller model that logs every command.
module tb_i2c_reg_seq_loader;
   logic        clk = 1'b0, arstn = 1'b0, start = 1'b0, verify = 1'b0;
   logic [0:0]  rom_addr, err_idx;
   logic [23:0] rom_data;
   logic [23:0] rom [2];
   logic        busy, done, err;
   int          checks = 0, errors = 0;

   i2c_reg_seq_loader_if bus_if ();

   i2c_reg_seq_loader #(
      .SLAVE_ADDR(7'h74), .ADDR_BYTES(2), .MEM_DEPTH(2),
      .PAUSE_CYCLES(10), .DELAY_UNIT(1000), .MAX_RETRY(3)
   ) dut (
      .clk_i(clk), .arstn_i(arstn), .start_i(start), .verify_i(verify),
      .rom_addr_o(rom_addr), .rom_data_i(rom_data), .bus(bus_if.master),
      .busy_o(busy), .done_o(done), .err_o(err), .err_idx_o(err_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   logic [12:0] cmd_log [$];
   int          cyc_log [$];
   int          cyc = 0, lat = 0, nack_at = -1;
   logic        acked = 1'b0, hold = 1'b0, mirror = 1'b1;
   logic [7:0]  rd_force = 8'h00, last_data = 8'h00;
   wire  [12:0] cmd_now = {bus_if.cmd_start, bus_if.cmd_stop, bus_if.cmd_read, bus_if.cmd_write, bus_if.cmd_ack_in, bus_if.cmd_din};
   wire         active = |cmd_now[12:9];

   always @(posedge clk) cyc <= cyc + 1;

   // byte controller: acks each command on its third sampled cycle, NACKs the command numbered nack_at
   always @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         bus_if.cmd_ack <= 1'b0;
         bus_if.ack_out <= 1'b0;
         bus_if.dout    <= 8'h00;
         lat            <= 0;
         acked          <= 1'b0;
      end else begin
         bus_if.cmd_ack <= 1'b0;
         if (!active) begin
            lat   <= 0;
            acked <= 1'b0;
         end else if (!acked && !hold) begin
            if (lat == 0) begin
               cmd_log.push_back(cmd_now);
               cyc_log.push_back(cyc);
            end
            lat <= lat + 1;
            if (lat == 2) begin
               bus_if.cmd_ack <= 1'b1;
               acked          <= 1'b1;
               bus_if.ack_out <= (cmd_log.size() - 1 == nack_at);
               bus_if.dout    <= mirror ? last_data : rd_force;
               if (cmd_now[11] && cmd_now[9]) last_data <= cmd_now[7:0];
            end
         end
      end
   end

   int done_cnt = 0, busy_bad = 0;
   always @(posedge clk) if (done) begin
      done_cnt <= done_cnt + 1;
      if (busy) busy_bad <= busy_bad + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        vfy;
      logic [23:0] e0, e1;
      logic        mir;
      logic [7:0]  force_v;
      int          nack;
      int          ncmd, n_e8, n_dw, n25;
      logic        xerr;
      logic [0:0]  xidx;
   } vec_t;

   localparam logic [23:0] A = 24'h0B24C0, B = 24'h0B2500, D0 = 24'hFFFF00, D3 = 24'hFFFF03;
   vec_t vecs [8];
   int   lat_arr [8];

   task automatic run_vec(input int i);
      vec_t v = vecs[i];
      int d0 = done_cnt, b0 = busy_bad, t0, e8 = 0, dw = 0, n25 = 0, bad = 0;
      logic [12:0] c;
      rom[0] = v.e0;
      rom[1] = v.e1;
      mirror = v.mir;
      rd_force = v.force_v;
      nack_at = v.nack;
      cmd_log.delete();
      cyc_log.delete();
      @(negedge clk);
      verify = v.vfy;
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      verify = !v.vfy;
      chk($sformatf("v%0d_busy_rise", i), busy, 1);
      for (int n = 0; n < 10000 && done_cnt == d0; n++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_done_once", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_busy_at_done", i), busy_bad - b0, 0);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      for (int k = 0; k < cmd_log.size(); k++) begin
         c = cmd_log[k];
         if (c[12] && c[7:0] == 8'hE8) e8++;
         if (c[11] && c[9]) dw++;
         if (c[9] && c[7:0] == 8'h25) n25++;
         if ((c[10] || c[9]) && (c[10] == c[9] || c[8] != c[10])) bad++;
      end
      chk($sformatf("v%0d_ncmd", i), cmd_log.size(), v.ncmd);
      chk($sformatf("v%0d_dev_wr_addr", i), e8, v.n_e8);
      chk($sformatf("v%0d_data_writes", i), dw, v.n_dw);
      chk($sformatf("v%0d_entry1_addr", i), n25, v.n25);
      chk($sformatf("v%0d_cmd_bits", i), bad, 0);
      chk($sformatf("v%0d_err", i), err, v.xerr);
      if (v.xerr) chk($sformatf("v%0d_err_idx", i), err_idx, v.xidx);
      lat_arr[i] = cyc_log.size() > 0 ? cyc_log[0] - t0 : -1;
   endtask

   logic [12:0] exp_wr [8];

   initial begin
      vecs[0] = '{1'b0, A,  B, 1'b1, 8'h00, -1,  8, 2, 2, 1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, A,  B, 1'b1, 8'h00, -1, 18, 4, 2, 2, 1'b0, 1'b0};
      vecs[2] = '{1'b1, A,  B, 1'b0, 8'h00, -1, 36, 8, 4, 0, 1'b1, 1'b0};
      vecs[3] = '{1'b0, A,  B, 1'b1, 8'h00,  1, 11, 3, 2, 1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, A,  B, 1'b1, 8'h00,  3, 12, 3, 3, 1, 1'b0, 1'b0};
      vecs[5] = '{1'b1, A,  B, 1'b1, 8'h00,  7, 27, 6, 3, 2, 1'b0, 1'b0};
      vecs[6] = '{1'b0, D0, B, 1'b1, 8'h00, -1,  4, 1, 1, 1, 1'b0, 1'b0};
      vecs[7] = '{1'b1, D3, B, 1'b1, 8'h00, -1,  9, 2, 1, 2, 1'b0, 1'b0};
      exp_wr = '{{5'b10010, 8'hE8}, {5'b00010, 8'h0B}, {5'b00010, 8'h24}, {5'b01010, 8'hC0},
                 {5'b10010, 8'hE8}, {5'b00010, 8'h0B}, {5'b00010, 8'h25}, {5'b01010, 8'h00}};
      rom[0] = A;
      rom[1] = B;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_idx", err_idx, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_cmd", cmd_now[12:8], 0);
      arstn = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) run_vec(i);
      run_vec(0);
      for (int k = 0; k < 8; k++) chk($sformatf("wr_seq%0d", k), cmd_log[k], exp_wr[k]);
      chk("gap_min", (cyc_log[4] - cyc_log[3]) >= 13, 1);
      run_vec(1);
      chk("vfy_dev_w", cmd_log[4], {5'b10010, 8'hE8});
      chk("vfy_addr_hi", cmd_log[5], {5'b00010, 8'h0B});
      chk("vfy_addr_lo", cmd_log[6], {5'b00010, 8'h24});
      chk("vfy_rstart", cmd_log[7], {5'b10010, 8'hE9});
      chk("vfy_read", cmd_log[8][12:8], 5'b01101);
      chk("delay_3000", lat_arr[7] - lat_arr[6], 3000);
      hold = 1'b1;
      rom[0] = A;
      rom[1] = B;
      @(negedge clk);
      verify = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 100 && !active; n++) @(negedge clk);
      chk("stall_active", active, 1);
      repeat (3) @(negedge clk);
      #2 arstn = 1'b0;
      #1;
      chk("arst_cmd", cmd_now[12:8], 0);
      chk("arst_busy", busy, 0);
      chk("arst_rom_addr", rom_addr, 0);
      @(negedge clk);
      arstn = 1'b1;
      hold = 1'b0;
      @(negedge clk);
      run_vec(0);
      chk("rerun_idx0", cmd_log[2][7:0], 8'h24);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
